pll_reset_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_reset_sequencer.sv | 144 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    // One extra bit of headroom so the counter can saturate above every terminal count.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state always uses non-blocking (<=) so both flops sample on the same edge.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-supervision sequencer. Optional lock timeout and retry
// limit are compiled in with `define PLL_SEQ_TIMEOUT_EN.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_locked,
    output logic       o_pll_reset,
    output logic       o_sys_reset,
    output logic       o_ready,
    output logic       o_error,
    output logic [3:0] o_retry_count
);

    localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    if (PLL_RST_CYCLES < 2 || LOCK_TIMEOUT < 4 || STABLE_CYCLES < 1 ||
        MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_param_check
        $error("pll_reset_sequencer: parameter out of range");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_s;
    logic             pll_reset_q, pll_reset_d;
    logic             sys_reset_q, sys_reset_d;
    logic             ready_q, ready_d;

`ifdef PLL_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    logic [3:0] retry_q, retry_d;
    logic       error_q, error_d;
`endif

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_i (reset),
        .d_i   (i_locked),
        .q_o   (lock_s)
    );

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
`ifdef PLL_SEQ_TIMEOUT_EN
        retry_d = retry_q;
`endif
        unique case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Lock is tested first so it beats a coincident timeout.
                if (lock_s) begin
                    state_d = ST_STABLE;
`ifdef PLL_SEQ_TIMEOUT_EN
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q >= RETRY_LIMIT) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_PLL_RST;
                        retry_d = retry_q + 4'd1;
                    end
`endif
                end
            end
            ST_STABLE: begin
                if (!lock_s)                    state_d = ST_PLL_RST;
                else if (cnt_q == STABLE_LAST)  state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) state_d = ST_PLL_RST;
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;
        else if (cnt_q != '1)   cnt_d = cnt_q + 1'b1;
        else                    cnt_d = cnt_q;

`ifdef PLL_SEQ_TIMEOUT_EN
        if (state_d == ST_RUN) retry_d = 4'd0;
        error_d = (state_d == ST_FAIL);
`endif
        // Outputs are decoded from the next state so they register on the transition edge.
        pll_reset_d = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
        sys_reset_d = (state_d != ST_RUN);
        ready_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_reset_q <= pll_reset_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
        end
    end

`ifdef PLL_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retry_q <= 4'd0;
            error_q <= 1'b0;
        end else begin
            retry_q <= retry_d;
            error_q <= error_d;
        end
    end

    assign o_error       = error_q;
    assign o_retry_count = retry_q;
`else
    assign o_error       = 1'b0;
    assign o_retry_count = 4'd0;
`endif

    assign o_pll_reset = pll_reset_q;
    assign o_sys_reset = sys_reset_q;
    assign o_ready     = ready_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer; timeout scenarios follow PLL_SEQ_TIMEOUT_EN.
module tb_pll_reset_sequencer;

    // Packed view of outputs: {pll_reset, sys_reset, ready, error, retry[3:0]}.
    localparam logic [7:0] O_PRST = 8'b1100_0000;
    localparam logic [7:0] O_WAIT = 8'b0100_0000;
    localparam logic [7:0] O_RUN  = 8'b0010_0000;
    localparam logic [7:0] O_FAIL = 8'b1101_0000;

    logic       clk;
    logic       reset;
    logic       i_locked;
    logic       o_pll_reset;
    logic       o_sys_reset;
    logic       o_ready;
    logic       o_error;
    logic [3:0] o_retry_count;
    logic [7:0] outs;
    logic [7:0] want;

    int n_cmp = 0;
    int n_err = 0;

    assign outs = {o_pll_reset, o_sys_reset, o_ready, o_error, o_retry_count};

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (32),
        .STABLE_CYCLES  (8),
        .MAX_RETRIES    (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_locked      (i_locked),
        .o_pll_reset   (o_pll_reset),
        .o_sys_reset   (o_sys_reset),
        .o_ready       (o_ready),
        .o_error       (o_error),
        .o_retry_count (o_retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        i_locked = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (outs !== O_PRST) begin
            n_err++;
            $display("FAIL reset_values: outs=%b want=%b", outs, O_PRST);
        end
    endtask

    task automatic test_power_up();
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            want = (k < 4) ? O_PRST : O_WAIT;
            n_cmp++;
            if (outs !== want) begin
                n_err++;
                $display("FAIL power_up_prst[%0d]: outs=%b want=%b", k, outs, want);
            end
        end
        i_locked = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            want = (k < 11) ? O_WAIT : O_RUN;
            n_cmp++;
            if (outs !== want) begin
                n_err++;
                $display("FAIL power_up_release[%0d]: outs=%b want=%b", k, outs, want);
            end
        end
    endtask

    task automatic test_lock_loss_run();
        i_locked = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            want = (k < 3) ? O_RUN : ((k < 7) ? O_PRST : O_WAIT);
            n_cmp++;
            if (outs !== want) begin
                n_err++;
                $display("FAIL run_lock_loss[%0d]: outs=%b want=%b", k, outs, want);
            end
        end
        i_locked = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            want = (k < 11) ? O_WAIT : O_RUN;
            n_cmp++;
            if (outs !== want) begin
                n_err++;
                $display("FAIL run_relock[%0d]: outs=%b want=%b", k, outs, want);
            end
        end
    endtask

    task automatic test_glitch_stable();
        i_locked = 1'b0;
        repeat (7) tick();
        n_cmp++;
        if (outs !== O_WAIT) begin
            n_err++;
            $display("FAIL glitch_setup: outs=%b want=%b", outs, O_WAIT);
        end
        i_locked = 1'b1;
        repeat (8) tick();
        // Lock drops 5 cycles into STABLE; its synchronized edge lands on the stable-count terminal cycle.
        i_locked = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            want = (k < 3) ? O_WAIT : O_PRST;
            n_cmp++;
            if (outs !== want) begin
                n_err++;
                $display("FAIL glitch_drop[%0d]: outs=%b want=%b", k, outs, want);
            end
        end
        i_locked = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            want = (k < 4) ? O_PRST : ((k < 13) ? O_WAIT : O_RUN);
            n_cmp++;
            if (outs !== want) begin
                n_err++;
                $display("FAIL glitch_recover[%0d]: outs=%b want=%b", k, outs, want);
            end
        end
    endtask

    task automatic test_async_reset();
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (outs !== O_PRST) begin
            n_err++;
            $display("FAIL async_reset: outs=%b want=%b", outs, O_PRST);
        end
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 3 || k == 4 || k == 12 || k == 13) begin
                want = (k < 4) ? O_PRST : ((k < 13) ? O_WAIT : O_RUN);
                n_cmp++;
                if (outs !== want) begin
                    n_err++;
                    $display("FAIL async_reset_recover[%0d]: outs=%b want=%b", k, outs, want);
                end
            end
        end
    endtask

`ifdef PLL_SEQ_TIMEOUT_EN
    task automatic test_timeouts();
        i_locked = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 108; e++) begin
            tick();
            if (e == 35 || e == 36 || e == 39 || e == 40 || e == 72 ||
                e == 76 || e == 107 || e == 108) begin
                case (e)
                    35:      want = O_WAIT;
                    36:      want = O_PRST | 8'd1;
                    39:      want = O_PRST | 8'd1;
                    40:      want = O_WAIT | 8'd1;
                    72:      want = O_PRST | 8'd2;
                    76:      want = O_WAIT | 8'd2;
                    107:     want = O_WAIT | 8'd2;
                    default: want = O_FAIL | 8'd2;
                endcase
                n_cmp++;
                if (outs !== want) begin
                    n_err++;
                    $display("FAIL timeout_seq[edge %0d]: outs=%b want=%b", e, outs, want);
                end
            end
        end
        i_locked = 1'b1;
        repeat (20) tick();
        n_cmp++;
        if (outs !== (O_FAIL | 8'd2)) begin
            n_err++;
            $display("FAIL fail_terminal: outs=%b want=%b", outs, O_FAIL | 8'd2);
        end
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (outs !== O_PRST) begin
            n_err++;
            $display("FAIL fail_reset: outs=%b want=%b", outs, O_PRST);
        end
        i_locked = 1'b0;
        tick();
        reset = 1'b0;
        // Lock becomes visible on exactly the cycle the first timeout would fire.
        for (int e = 1; e <= 44; e++) begin
            tick();
            if (e == 33) i_locked = 1'b1;
            if (e == 35 || e == 36 || e == 43 || e == 44) begin
                want = (e < 44) ? O_WAIT : O_RUN;
                n_cmp++;
                if (outs !== want) begin
                    n_err++;
                    $display("FAIL lock_vs_timeout[edge %0d]: outs=%b want=%b", e, outs, want);
                end
            end
        end
    endtask
`else
    task automatic test_no_timeout();
        i_locked = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 10000; e++) begin
            tick();
            if (e == 4 || e == 5000 || e == 10000) begin
                n_cmp++;
                if (outs !== O_WAIT) begin
                    n_err++;
                    $display("FAIL no_timeout_wait[edge %0d]: outs=%b want=%b", e, outs, O_WAIT);
                end
            end
        end
        i_locked = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            want = (k < 11) ? O_WAIT : O_RUN;
            n_cmp++;
            if (outs !== want) begin
                n_err++;
                $display("FAIL no_timeout_lock[%0d]: outs=%b want=%b", k, outs, want);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_power_up();
        test_lock_loss_run();
        test_glitch_stable();
        test_async_reset();
`ifdef PLL_SEQ_TIMEOUT_EN
        test_timeouts();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
